interval_timer: RTL and testbench

Countdown timer that sits directly downstream of `Time_Parameters` in the traffic light controller. On a start request from the controller FSM it captures the 4-bit `Value` (seconds) that `Time_Parameters` presents. It then counts down once per second, using an internal prescaler that divides `clk`, and pulses `Expired` for one cycle when the interval has elapsed. The FSM uses that pulse to advance the light sequence.

---
 rtl/traffic_pkg.sv | 13 +
 rtl/one_hz_prescaler.sv | 37 +++
 rtl/interval_timer.sv | 87 ++++++++
 tb/tb_interval_timer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: timer state encoding,
// interval width and the board-level one-second divider.
package traffic_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } timer_state_e;

  localparam int TIME_W          = 4;
  localparam int CLK_DIV_DEFAULT = 100_000_000;

endpackage

// File: rtl/one_hz_prescaler.sv
// Free-running divider that flags the last clk cycle of each second while run is high.
module one_hz_prescaler
  import traffic_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int CNT_W   = 27
) (
  input  logic clk,
  input  logic Reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  logic [CNT_W-1:0] count_q, count_d;

  // tick is combinational so the owner can act on the same edge the counter wraps
  assign tick = run && (count_q == CNT_W'(CLK_DIV - 1));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (run) begin
      count_d = tick ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/interval_timer.sv
// Seconds countdown timer: loads Value on Start_Timer, decrements once per
// prescaler tick and pulses Expired when the interval completes.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int CNT_W   = 27
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Sync_Reset,
  input  logic              Start_Timer,
  input  logic [TIME_W-1:0] Value,
  output logic              Expired,
  output logic              Busy,
  output logic [TIME_W-1:0] Remaining,
  output logic              Tick_1Hz
);

  timer_state_e      state_q, state_d;
  logic [TIME_W-1:0] rem_q, rem_d;
  logic              expired_q, expired_d;
  logic              tick_q, tick_d;
  logic              presc_tick, presc_clear, presc_run;

  one_hz_prescaler #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .Reset (Reset),
    .clear (presc_clear),
    .run   (presc_run),
    .tick  (presc_tick)
  );

  assign presc_run   = (state_q == COUNT);
  assign presc_clear = Sync_Reset || Start_Timer || (state_q == IDLE);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    expired_d = 1'b0;
    tick_d    = 1'b0;
    if (Sync_Reset) begin
      state_d = IDLE;
      rem_d   = '0;
    end else if (Start_Timer) begin
      // a start pre-empts any tick landing on the same edge
      if (Value != '0) begin
        state_d = COUNT;
        rem_d   = Value;
      end else begin
        state_d   = IDLE;
        rem_d     = '0;
        expired_d = 1'b1;
      end
    end else if ((state_q == COUNT) && presc_tick) begin
      tick_d = 1'b1;
      rem_d  = rem_q - 1'b1;
      if (rem_q == TIME_W'(1)) begin
        state_d   = IDLE;
        expired_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      expired_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      expired_q <= expired_d;
      tick_q    <= tick_d;
    end
  end

  assign Expired   = expired_q;
  assign Busy      = (state_q == COUNT);
  assign Remaining = rem_q;
  assign Tick_1Hz  = tick_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with CLK_DIV = 4; expected Expired cycles
// are queued by the stimulus and consumed by an independent monitor.
module tb_interval_timer;

  logic       clk = 1'b0;
  logic       Reset;
  logic       Sync_Reset;
  logic       Start_Timer;
  logic [3:0] Value;
  logic       Expired;
  logic       Busy;
  logic [3:0] Remaining;
  logic       Tick_1Hz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];

  interval_timer #(
    .CLK_DIV (4),
    .CNT_W   (3)
  ) dut (
    .clk         (clk),
    .Reset       (Reset),
    .Sync_Reset  (Sync_Reset),
    .Start_Timer (Start_Timer),
    .Value       (Value),
    .Expired     (Expired),
    .Busy        (Busy),
    .Remaining   (Remaining),
    .Tick_1Hz    (Tick_1Hz)
  );

  always #5us clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: every Expired pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!Reset && Expired) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_expired", cyc, -1);
      end else begin
        chk("expired_cycle", cyc, exp_q.pop_front());
      end
    end
  end

  task automatic start(input logic [3:0] v, output int e0);
    Start_Timer = 1'b1;
    Value       = v;
    e0          = cyc + 1;
    @(negedge clk);
    Start_Timer = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #20ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int e0, e1;
    Reset       = 1'b1;
    Sync_Reset  = 1'b0;
    Start_Timer = 1'b0;
    Value       = 4'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {Expired, Busy, Remaining, Tick_1Hz}, 0);
    Reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_outputs", {Expired, Busy, Remaining, Tick_1Hz}, 0);
    end

    // Value = 5: one decrement every 4 cycles, expiry at e0+20
    start(4'd5, e0);
    exp_q.push_back(e0 + 20);
    Value = 4'd9;
    for (int i = 0; i <= 20; i++) begin
      chk("v5_remaining", Remaining, 5 - i / 4);
      chk("v5_busy", Busy, (i < 20) ? 1 : 0);
      if (i < 20) chk("v5_tick", Tick_1Hz, (i > 0 && i % 4 == 0) ? 1 : 0);
      @(negedge clk);
    end
    repeat (5) @(negedge clk);
    chk("v5_busy_after", Busy, 0);

    // Value = 3 then restart with 2 at e0+6: expiry moves to e0+14
    start(4'd3, e0);
    wait_until(e0 + 5);
    start(4'd2, e1);
    chk("restart_edge", e1, e0 + 6);
    exp_q.push_back(e0 + 14);
    Value = 4'hF;
    wait_until(e0 + 9);
    chk("restart_rem_9", Remaining, 2);
    wait_until(e0 + 12);
    chk("restart_rem_12", Remaining, 1);
    chk("restart_busy_12", Busy, 1);
    wait_until(e0 + 18);
    chk("restart_busy_end", Busy, 0);

    // Zero-length interval
    start(4'd0, e0);
    exp_q.push_back(e0);
    chk("zero_busy_0", Busy, 0);
    @(negedge clk);
    chk("zero_busy_1", Busy, 0);
    repeat (4) @(negedge clk);

    // Sync_Reset mid-count, then on the expiry edge
    start(4'd4, e0);
    wait_until(e0 + 8);
    Sync_Reset = 1'b1;
    @(negedge clk);
    Sync_Reset = 1'b0;
    chk("sync_rem", Remaining, 0);
    chk("sync_busy", Busy, 0);
    wait_until(e0 + 40);
    chk("sync_still_idle", Busy, 0);
    start(4'd1, e0);
    wait_until(e0 + 3);
    Sync_Reset = 1'b1;
    @(negedge clk);
    Sync_Reset = 1'b0;
    chk("sync_expiry_busy", Busy, 0);
    chk("sync_expiry_rem", Remaining, 0);
    repeat (10) @(negedge clk);

    // Async reset between clock edges, then a fresh 1 s interval
    start(4'd2, e0);
    chk("async_pre_busy", Busy, 1);
    Reset = 1'b1;
    #1us;
    chk("async_busy", Busy, 0);
    chk("async_rem", Remaining, 0);
    @(negedge clk);
    Reset = 1'b0;
    repeat (6) @(negedge clk);
    chk("async_after_busy", Busy, 0);
    chk("async_after_rem", Remaining, 0);
    start(4'd1, e0);
    exp_q.push_back(e0 + 4);
    chk("v1_rem", Remaining, 1);
    wait_until(e0 + 8);
    chk("v1_busy_end", Busy, 0);

    repeat (4) @(negedge clk);
    chk("pending_expiries", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
